// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline registers:
// bundle field positions, default widths and the occupancy state type.
package pipe_pkg;

  localparam logic [31:0] WORD_ZERO = 32'h0000_0000;

  // EX/MEM control bundle, MSB first: {mem_write, mem_read, reg_write, mem_to_reg}
  localparam int EXMEM_MEM_WRITE  = 3;
  localparam int EXMEM_MEM_READ   = 2;
  localparam int EXMEM_REG_WRITE  = 1;
  localparam int EXMEM_MEM_TO_REG = 0;
  localparam int EXMEM_CTRL_W     = 4;
  localparam int EXMEM_DATA_W     = 70;

  // MEM/WB control bundle, MSB first: {reg_write, mem_to_reg}
  localparam int MEMWB_REG_WRITE  = 1;
  localparam int MEMWB_MEM_TO_REG = 0;
  localparam int MEMWB_CTRL_W     = 2;
  localparam int MEMWB_DATA_W     = 69;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  function automatic logic stage_can_accept(input stage_state_e s);
    return s != TWO;
  endfunction

endpackage

// File: rtl/pipeline_stage_entry.sv
// One {valid, ctrl, data} storage slot. Clear wins over load; with neither
// asserted the slot holds its contents.
module pipeline_stage_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int DATA_W = EXMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = load_ctrl;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipeline_stage_reg.sv
// Elastic pipeline register between two stages: valid/ready handshake, flush,
// and an optional skid entry so that in_ready can be a plain flop.
module pipeline_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  stage_state_e      state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              accept, consume;
  logic              main_load, main_clear, skid_load, skid_clear;
  logic [CTRL_W-1:0] main_src_ctrl;
  logic [DATA_W-1:0] main_src_data;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  assign accept  = in_valid && in_ready;
  assign consume = main_valid && out_ready;

  // Flush beats every other event; a flushed incoming beat is simply not loaded.
  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_clear    = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    main_src_ctrl = in_ctrl;
    main_src_data = in_data;
    if (flush) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_load = 1'b1;
          end else if (accept) begin
            if (SKID != 0) begin
              skid_load = 1'b1;
              state_d   = TWO;
            end else begin
              main_load = 1'b1;
            end
          end else if (consume) begin
            main_clear = 1'b1;
            state_d    = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            main_load     = 1'b1;
            main_src_ctrl = skid_ctrl;
            main_src_data = skid_data;
            skid_clear    = 1'b1;
            state_d       = ONE;
          end
        end
        default: begin
          state_d    = EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
    in_ready_d = stage_can_accept(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  pipeline_stage_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk       (clk),
    .rst       (rst),
    .load      (main_load),
    .clear     (main_clear),
    .load_ctrl (main_src_ctrl),
    .load_data (main_src_data),
    .valid     (main_valid),
    .ctrl      (main_ctrl),
    .data      (main_data)
  );

  if (SKID != 0) begin : g_skid
    pipeline_stage_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .load      (skid_load),
      .clear     (skid_clear),
      .load_ctrl (in_ctrl),
      .load_data (in_data),
      .valid     (skid_valid),
      .ctrl      (skid_ctrl),
      .data      (skid_data)
    );
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_ctrl  = '0;
    assign skid_data  = '0;
  end

  // With a skid entry in_ready is a flop; without one it tracks out_ready directly.
  always_comb begin
    if (SKID != 0) begin
      in_ready = in_ready_q && !rst;
    end else begin
      in_ready = (!main_valid || out_ready) && !rst;
    end
  end

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_valid ? main_data : '0;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule
